// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD ALU.
// No logic; no latency; no backpressure.
package bcd_pkg;

    typedef enum logic [1:0] {
        OP_CLR = 2'b00,
        OP_ADD = 2'b01,
        OP_SUB = 2'b10,
        OP_ADC = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_adder.sv
// Single BCD digit add with decimal correction and optional 9's complement of b.
// Purely combinational; no backpressure.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    input  logic       sub,
    output bcd_digit_t sum,
    output logic       cout,
    output logic       bad
);

    bcd_digit_t b_eff;
    logic [4:0] s;

    always_comb begin
        b_eff = sub ? (BCD_MAX - b) : b;
        s     = {1'b0, a} + {1'b0, b_eff} + 5'(cin);
        sum   = s[3:0];
        cout  = 1'b0;
        // Binary sums 10..19 wrap into the next decade: add 6, keep low nibble.
        if (s > 5'(BCD_MAX)) begin
            sum  = s[3:0] + 4'd6;
            cout = 1'b1;
        end
        bad = (a > BCD_MAX) || (b > BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_alu.sv
// Digit-serial BCD add/sub/adc/clr, one digit per clock, LSD first.
// Latency NUM_DIGITS cycles from start edge to done; start ignored while busy.
module bcd_serial_alu
    import bcd_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    localparam int DW         = 4 * NUM_DIGITS
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic [1:0]    opcode,
    input  logic [DW-1:0] op1,
    input  logic [DW-1:0] op2,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          c_out,
    output logic          invalid
);

    localparam int            IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    state_e          state_q, state_d;
    opcode_e         op_q;
    logic [IW-1:0]   idx_q;
    logic [DW-1:0]   a_sr, b_sr, res_sr, res_full;
    logic            carry_q, bad_q;
    bcd_digit_t      dig_sum;
    logic            dig_cout, dig_bad;
    logic            accept, last;

    bcd_digit_adder u_digit (
        .a    (a_sr[3:0]),
        .b    (b_sr[3:0]),
        .cin  (carry_q),
        .sub  (op_q == OP_SUB),
        .sum  (dig_sum),
        .cout (dig_cout),
        .bad  (dig_bad)
    );

    // New digit enters at the top so digit 0 lands at the bottom after N shifts.
    generate
        if (NUM_DIGITS == 1) begin : g_one
            assign res_full = dig_sum;
        end else begin : g_many
            assign res_full = {dig_sum, res_sr[DW-1:4]};
        end
    endgenerate

    assign accept = start && (state_q != S_RUN);
    assign last   = (state_q == S_RUN) && (idx_q == LAST);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (idx_q == LAST) state_d = S_DONE;
            default: state_d = start ? S_RUN : S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            op_q    <= OP_CLR;
            idx_q   <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry_q <= 1'b0;
            bad_q   <= 1'b0;
            result  <= '0;
            c_out   <= 1'b0;
            invalid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= opcode_e'(opcode);
                a_sr    <= op1;
                b_sr    <= op2;
                res_sr  <= '0;
                idx_q   <= '0;
                bad_q   <= 1'b0;
                case (opcode_e'(opcode))
                    OP_SUB:  carry_q <= 1'b1;
                    OP_ADC:  carry_q <= c_out;
                    default: carry_q <= 1'b0;
                endcase
            end else if (state_q == S_RUN) begin
                a_sr    <= a_sr >> 4;
                b_sr    <= b_sr >> 4;
                res_sr  <= res_full;
                carry_q <= dig_cout;
                bad_q   <= bad_q | dig_bad;
                idx_q   <= idx_q + IW'(1);
                if (last) begin
                    if (op_q == OP_CLR) begin
                        result  <= '0;
                        c_out   <= 1'b0;
                        invalid <= 1'b0;
                    end else if (bad_q || dig_bad) begin
                        result  <= '0;
                        c_out   <= 1'b0;
                        invalid <= 1'b1;
                    end else begin
                        result  <= res_full;
                        // Subtraction reports borrow: no final carry means op1 < op2.
                        c_out   <= (op_q == OP_SUB) ? ~dig_cout : dig_cout;
                        invalid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Directed checks of the digit-serial BCD ALU at 2 and 4 digits.
module tb_bcd_serial_alu;

    logic        tb_clk = 1'b0;
    logic        nrst   = 1'b0;

    logic        start2 = 1'b0, start4 = 1'b0;
    logic [1:0]  opc2 = 2'b00, opc4 = 2'b00;
    logic [7:0]  a2 = '0, b2 = '0;
    logic [15:0] a4 = '0, b4 = '0;
    logic        busy2, done2, cout2, inv2;
    logic        busy4, done4, cout4, inv4;
    logic [7:0]  res2;
    logic [15:0] res4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 tb_clk = ~tb_clk;

    bcd_serial_alu #(.NUM_DIGITS(2)) u_dut2 (
        .clk(tb_clk), .nrst(nrst), .start(start2), .opcode(opc2),
        .op1(a2), .op2(b2), .busy(busy2), .done(done2),
        .result(res2), .c_out(cout2), .invalid(inv2)
    );

    bcd_serial_alu #(.NUM_DIGITS(4)) u_dut4 (
        .clk(tb_clk), .nrst(nrst), .start(start4), .opcode(opc4),
        .op1(a4), .op2(b4), .busy(busy4), .done(done4),
        .result(res4), .c_out(cout4), .invalid(inv4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start for one edge; returns at the negedge just after the capture edge.
    task automatic start_op(input bit sel, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge tb_clk);
        if (sel) begin start4 = 1'b1; opc4 = op; a4 = a; b4 = b; end
        else     begin start2 = 1'b1; opc2 = op; a2 = a[7:0]; b2 = b[7:0]; end
        @(posedge tb_clk);
        @(negedge tb_clk);
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    // Waits for done, checking how many cycles it took and how many were busy.
    task automatic wait_done(input bit sel, input int exp_lat, input string tag);
        int m = 0;
        int bcnt = 0;
        while (((sel ? done4 : done2) !== 1'b1) && m < 40) begin
            if ((sel ? busy4 : busy2) === 1'b1) bcnt++;
            @(negedge tb_clk);
            m++;
        end
        check_val({tag, " latency"}, m, exp_lat);
        check_val({tag, " busy cycles"}, bcnt, exp_lat);
        check_val({tag, " busy low in done"}, sel ? busy4 : busy2, 1'b0);
    endtask

    task automatic check2(input string tag, input logic [7:0] r, input logic c, input logic inv);
        check_val({tag, " result"}, res2, r);
        check_val({tag, " c_out"}, cout2, c);
        check_val({tag, " invalid"}, inv2, inv);
    endtask

    task automatic check4(input string tag, input logic [15:0] r, input logic c, input logic inv);
        check_val({tag, " result"}, res4, r);
        check_val({tag, " c_out"}, cout4, c);
        check_val({tag, " invalid"}, inv4, inv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        repeat (2) @(negedge tb_clk);
        check_val("reset busy2", busy2, 1'b0);
        check_val("reset done2", done2, 1'b0);
        check2("reset n2", 8'h00, 1'b0, 1'b0);
        check4("reset n4", 16'h0000, 1'b0, 1'b0);
        nrst = 1'b1;

        // 37 + 12
        start_op(1'b0, 2'b01, 16'h0037, 16'h0012);
        wait_done(1'b0, 2, "add37");
        check2("add37", 8'h49, 1'b0, 1'b0);

        // 81 + 81 carries out
        start_op(1'b0, 2'b01, 16'h0081, 16'h0081);
        wait_done(1'b0, 2, "add81");
        check2("add81", 8'h62, 1'b1, 1'b0);

        // 99 - 55; previous result must hold during RUN
        start_op(1'b0, 2'b10, 16'h0099, 16'h0055);
        check_val("hold during run", res2, 8'h62);
        wait_done(1'b0, 2, "sub99");
        check2("sub99", 8'h44, 1'b0, 1'b0);

        // 12 - 34 borrows, 10's complement result
        start_op(1'b0, 2'b10, 16'h0012, 16'h0034);
        wait_done(1'b0, 2, "sub12");
        check2("sub12", 8'h78, 1'b1, 1'b0);

        // Invalid digit in op1
        start_op(1'b0, 2'b01, 16'h00A1, 16'h0001);
        wait_done(1'b0, 2, "badA1");
        check2("badA1", 8'h00, 1'b0, 1'b1);

        start_op(1'b0, 2'b01, 16'h0015, 16'h0005);
        wait_done(1'b0, 2, "add15");
        check2("add15", 8'h20, 1'b0, 1'b0);

        // CLR
        start_op(1'b0, 2'b00, 16'h0012, 16'h0034);
        wait_done(1'b0, 2, "clr");
        check2("clr", 8'h00, 1'b0, 1'b0);

        // 4-digit wrap-around then ADC consuming the carry
        start_op(1'b1, 2'b01, 16'h9999, 16'h0001);
        wait_done(1'b1, 4, "wrap");
        check4("wrap", 16'h0000, 1'b1, 1'b0);

        start_op(1'b1, 2'b11, 16'h0000, 16'h0000);
        wait_done(1'b1, 4, "adc");
        check4("adc", 16'h0001, 1'b0, 1'b0);

        // Start during RUN is ignored
        start_op(1'b1, 2'b01, 16'h1234, 16'h1111);
        start4 = 1'b1; opc4 = 2'b10; a4 = 16'h9999; b4 = 16'h9999;
        @(negedge tb_clk);
        start4 = 1'b0;
        wait_done(1'b1, 3, "ignore");
        check4("ignore", 16'h2345, 1'b0, 1'b0);

        // Back-to-back start in the DONE cycle
        start4 = 1'b1; opc4 = 2'b01; a4 = 16'h0100; b4 = 16'h0200;
        @(posedge tb_clk);
        @(negedge tb_clk);
        start4 = 1'b0;
        check_val("b2b busy", busy4, 1'b1);
        check_val("b2b hold", res4, 16'h2345);
        wait_done(1'b1, 4, "b2b");
        check4("b2b", 16'h0300, 1'b0, 1'b0);

        // Reset one cycle into RUN after a nonzero result
        start_op(1'b1, 2'b01, 16'h8765, 16'h4321);
        @(negedge tb_clk);
        nrst = 1'b0;
        #1;
        check_val("rst busy", busy4, 1'b0);
        check_val("rst done", done4, 1'b0);
        check4("rst mid", 16'h0000, 1'b0, 1'b0);
        @(negedge tb_clk);
        nrst = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge tb_clk);
            if (done4 === 1'b1 || busy4 === 1'b1) dcnt++;
        end
        check_val("no done after reset", dcnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_serial_alu.md
Name: bcd_serial_alu

Overview:
- Parametrised, multi-digit, digit-serial BCD arithmetic unit. Successor to the fixed 2-digit combinational BCD add/subtract ALU.
- Processes one BCD digit per clock, least-significant digit first, under a start/done handshake.
- Adds borrow-correct subtraction, chained add-with-carry for multi-word operands, and invalid-digit detection.
- Sits between the keypad/operand registers and the 7-segment display driver.

Parameters:
- NUM_DIGITS, 4, number of BCD digits per operand (valid range 1 to 16).
- DW, 4*NUM_DIGITS, operand/result width in bits (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- start  in  1  request a new operation; sampled only when accepting.
- opcode  in  2  00 CLR, 01 ADD, 10 SUB, 11 ADC.
- op1  in  DW  BCD operand A, digit 0 in bits [3:0].
- op2  in  DW  BCD operand B.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  DW  registered BCD result.
- c_out  out  1  carry (ADD/ADC) or borrow (SUB).
- invalid  out  1  some operand digit was greater than 9 in the last operation.

Behaviour:
- Clock and reset: single clock, clk. Reset nrst is asynchronous, active-low.
- Reset values: busy=0, done=0, result=0, c_out=0, invalid=0. State=IDLE, digit index=0, internal carry=0.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1: at edge k, capture op1, op2 and opcode, clear the index, set the initial carry, go to RUN.
- RUN: at each edge k+1 to k+N, process digit[idx]. At edge k+N go to DONE.
- DONE: lasts one cycle, then IDLE unless a new start is accepted (back-to-back allowed).
- busy=1 in RUN. done=1 in DONE only. done goes high N cycles after the start edge.
- start in RUN is ignored. Operand changes after capture have no effect.
- Initial carry by opcode:
  - ADD: 0.
  - ADC: the current c_out register.
  - SUB: 1. op2 digits are replaced by their 9's complement, giving a 10's-complement add.
- Per-digit rule: s = a + b + cin in 5 bits. If s > 9, digit = s + 6 (mod 16) and cout = 1; otherwise digit = s and cout = 0.
- Final flags:
  - ADD/ADC: c_out = final carry.
  - SUB: c_out = NOT final carry (1 means op1 < op2). result is then the 10^N complement, e.g. 12-34 gives 78.
- CLR: same latency; result=0, c_out=0, invalid=0.
- Invalid digits: any captured op1/op2 digit greater than 9 sets a sticky flag for the operation. At completion, invalid=1, result=0, c_out=0.
- Output timing: result, c_out and invalid update only at edge k+N, when entering DONE. They hold through the next operation's RUN phase.
- Wrap-around: all-9s plus 1 gives result 0, c_out 1.
- Reset mid-operation: immediate return to reset values. The partial result is discarded and no done pulse is produced.

Decomposition:
- bcd_pkg:
  - opcode enum (OP_CLR, OP_ADD, OP_SUB, OP_ADC).
  - state enum (S_IDLE, S_RUN, S_DONE).
  - bcd_digit_t typedef (logic [3:0]).
  - constant BCD_MAX=9.
- Sub-module bcd_digit_adder, combinational:
  - Inputs: a, b, cin, sub.
  - Outputs: sum, cout, bad.
  - sub applies the 9's complement to b. bad flags a or b greater than 9.
- Top level: FSM, index counter, working shift register, output registers.

Test Plan:
1. NUM_DIGITS=2, ADD 37+12 -> done high 2 cycles after start, result=8'h49, c_out=0. busy is high for exactly 2 cycles.
2. NUM_DIGITS=2, ADD 81+81 -> result=8'h62, c_out=1. Then SUB 99-55 -> result=8'h44, c_out=0. Then SUB 12-34 -> result=8'h78, c_out=1.
3. NUM_DIGITS=4, ADD 9999+0001 -> result=16'h0000, c_out=1. Then ADC 0000+0000 -> result=16'h0001, c_out=0.
4. NUM_DIGITS=2, ADD op1=8'hA1, op2=8'h01 -> invalid=1, result=0, c_out=0. Then ADD 15+05 -> result=8'h20, invalid=0.
5. NUM_DIGITS=4, start ADD; pulse start again with different operands during RUN -> ignored, first result delivered. Then assert start in the DONE cycle -> accepted, second done 4 cycles later.
6. NUM_DIGITS=4, deassert nrst one cycle into RUN -> busy, done, result, c_out and invalid all go to 0 immediately. No done pulse after reset is released.
